// File: rtl/lane_remap_table.sv
// Maps LANES logical lanes onto LANES+SPARES physical lanes, skipping faulty ones.
// Rebuilds go into a shadow table that is committed in one cycle.
module lane_remap_table #(
  parameter int LANES      = 8,
  parameter int SPARES     = 2,
  parameter int ADDR_WIDTH = $clog2(LANES + SPARES),
  parameter int CNT_WIDTH  = $clog2(LANES + SPARES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load_valid,
  input  logic [LANES+SPARES-1:0] i_load_mask,
  output logic                  o_load_ready,
  input  logic                  i_fault_valid,
  input  logic [ADDR_WIDTH-1:0] i_fault_lane,
  input  logic                  i_bypass,
  input  logic                  i_q_req,
  input  logic [ADDR_WIDTH-1:0] i_q_logical,
  output logic                  o_q_valid,
  output logic [ADDR_WIDTH-1:0] o_q_phys,
  output logic                  o_q_ok,
  input  logic                  i_dump_req,
  output logic                  o_dump_valid,
  output logic [ADDR_WIDTH-1:0] o_dump_idx,
  output logic [ADDR_WIDTH-1:0] o_dump_data,
  output logic                  o_busy,
  output logic                  o_build_done,
  output logic                  o_map_fail,
  output logic [LANES-1:0]      o_lane_ok,
  output logic [CNT_WIDTH-1:0]  o_healthy_cnt
);

  // state  | meaning
  // IDLE   | accepting loads, fault reports and dump requests
  // BUILD  | scanning physical lanes p = 0..PHYS-1 into the shadow table
  // FINISH | committing shadow table, status and healthy count
  // DUMP   | streaming LANES committed entries

  localparam int PHYS = LANES + SPARES;
  localparam int LIDX = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_WIDTH:0]   PHYS_A  = (ADDR_WIDTH + 1)'(PHYS);
  localparam logic [ADDR_WIDTH:0]   LANES_A = (ADDR_WIDTH + 1)'(LANES);
  localparam logic [CNT_WIDTH-1:0]  LANES_C = CNT_WIDTH'(LANES);
  localparam logic [ADDR_WIDTH-1:0] P_LAST  = ADDR_WIDTH'(PHYS - 1);
  localparam logic [LIDX-1:0]       D_LAST  = LIDX'(LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_FINISH, S_DUMP} state_t;

  state_t                r_state, w_state_nxt;
  logic [PHYS-1:0]       r_fault_mask, r_pend_mask;
  logic                  r_pending;
  logic [ADDR_WIDTH-1:0] r_table  [LANES];
  logic [ADDR_WIDTH-1:0] r_shadow [LANES];
  logic [LANES-1:0]      r_lane_ok, r_shadow_ok;
  logic [ADDR_WIDTH-1:0] r_p;
  logic [CNT_WIDTH-1:0]  r_l;
  logic [LIDX-1:0]       r_dump_cnt;
  logic [CNT_WIDTH-1:0]  r_healthy;
  logic                  r_map_fail;
  logic                  r_q_valid, r_q_ok;
  logic [ADDR_WIDTH-1:0] r_q_phys;

  logic                  w_fault_ok;
  logic [PHYS-1:0]       w_fault_bits;
  logic                  w_start;
  logic [CNT_WIDTH-1:0]  w_healthy;
  logic                  w_q_in_range;
  logic [LIDX-1:0]       w_q_idx;
  logic [LIDX-1:0]       w_l_idx;
  logic                  w_l_room;

  // Out-of-range fault reports are dropped everywhere, including pending merges.
  assign w_fault_ok   = i_fault_valid && ({1'b0, i_fault_lane} < PHYS_A);
  assign w_fault_bits = w_fault_ok ? (PHYS'(1) << i_fault_lane) : '0;
  assign w_start      = i_load_valid || w_fault_ok || r_pending;
  assign w_q_in_range = {1'b0, i_q_logical} < LANES_A;
  assign w_q_idx      = i_q_logical[LIDX-1:0];
  assign w_l_idx      = r_l[LIDX-1:0];
  assign w_l_room     = r_l < LANES_C;

  always_comb begin
    w_healthy = '0;
    for (int i = 0; i < PHYS; i++) w_healthy = w_healthy + CNT_WIDTH'(!r_fault_mask[i]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start)         w_state_nxt = S_BUILD;
        else if (i_dump_req) w_state_nxt = S_DUMP;
      end
      S_BUILD:  if (r_p == P_LAST) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      S_DUMP:   if (r_dump_cnt == D_LAST) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fault_mask <= '0;
      r_pend_mask  <= '0;
      r_pending    <= 1'b0;
      r_lane_ok    <= '1;
      r_shadow_ok  <= '1;
      r_p          <= '0;
      r_l          <= '0;
      r_dump_cnt   <= '0;
      r_healthy    <= CNT_WIDTH'(PHYS);
      r_map_fail   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_table[i]  <= ADDR_WIDTH'(i);
        r_shadow[i] <= ADDR_WIDTH'(i);
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dump_cnt <= '0;
          if (i_load_valid) begin
            r_fault_mask <= i_load_mask | w_fault_bits;
          end else if (w_fault_ok) begin
            r_fault_mask <= r_fault_mask | w_fault_bits;
          end else if (r_pending) begin
            r_fault_mask <= r_fault_mask | r_pend_mask;
            r_pend_mask  <= '0;
            r_pending    <= 1'b0;
          end
          // Unfilled entries keep the committed physical lane, so seed from it.
          if (w_start) begin
            r_p         <= '0;
            r_l         <= '0;
            r_shadow    <= r_table;
            r_shadow_ok <= '0;
          end
        end
        S_BUILD: begin
          if (!r_fault_mask[r_p] && w_l_room) begin
            r_shadow[w_l_idx]    <= r_p;
            r_shadow_ok[w_l_idx] <= 1'b1;
            r_l                  <= r_l + CNT_WIDTH'(1);
          end
          r_p <= r_p + ADDR_WIDTH'(1);
        end
        S_FINISH: begin
          r_table    <= r_shadow;
          r_lane_ok  <= r_shadow_ok;
          r_healthy  <= w_healthy;
          r_map_fail <= w_l_room;
        end
        S_DUMP: r_dump_cnt <= r_dump_cnt + LIDX'(1);
        default: ;
      endcase
      if (r_state != S_IDLE && w_fault_ok) begin
        r_pend_mask <= r_pend_mask | w_fault_bits;
        r_pending   <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q_valid <= 1'b0;
      r_q_phys  <= '0;
      r_q_ok    <= 1'b0;
    end else begin
      r_q_valid <= i_q_req;
      if (i_q_req) begin
        if (!w_q_in_range) begin
          r_q_phys <= '0;
          r_q_ok   <= 1'b0;
        end else if (i_bypass) begin
          r_q_phys <= i_q_logical;
          r_q_ok   <= 1'b1;
        end else begin
          r_q_phys <= r_table[w_q_idx];
          r_q_ok   <= r_lane_ok[w_q_idx];
        end
      end
    end
  end

  assign o_load_ready  = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_build_done  = (r_state == S_FINISH);
  assign o_dump_valid  = (r_state == S_DUMP);
  assign o_dump_idx    = o_dump_valid ? ADDR_WIDTH'(r_dump_cnt) : '0;
  assign o_dump_data   = o_dump_valid ? r_table[r_dump_cnt] : '0;
  assign o_q_valid     = r_q_valid;
  assign o_q_phys      = r_q_phys;
  assign o_q_ok        = r_q_ok;
  assign o_map_fail    = r_map_fail;
  assign o_lane_ok     = r_lane_ok;
  assign o_healthy_cnt = r_healthy;

endmodule

// File: tb/tb_lane_remap_table.sv
// Directed plus randomized checks of lane_remap_table against a list-based model
// of the healthy-lane assignment.
module tb_lane_remap_table;

  localparam int LANES = 8;
  localparam int SPARES = 2;
  localparam int PHYS = LANES + SPARES;
  localparam int AW = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_valid = 1'b0;
  logic [PHYS-1:0] load_mask = '0;
  logic            load_ready;
  logic            fault_valid = 1'b0;
  logic [AW-1:0]   fault_lane = '0;
  logic            bypass = 1'b0;
  logic            q_req = 1'b0;
  logic [AW-1:0]   q_logical = '0;
  logic            q_valid;
  logic [AW-1:0]   q_phys;
  logic            q_ok;
  logic            dump_req = 1'b0;
  logic            dump_valid;
  logic [AW-1:0]   dump_idx;
  logic [AW-1:0]   dump_data;
  logic            busy;
  logic            build_done;
  logic            map_fail;
  logic [LANES-1:0] lane_ok;
  logic [CW-1:0]   healthy_cnt;

  lane_remap_table #(.LANES(LANES), .SPARES(SPARES)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_load_valid(load_valid), .i_load_mask(load_mask), .o_load_ready(load_ready),
    .i_fault_valid(fault_valid), .i_fault_lane(fault_lane),
    .i_bypass(bypass), .i_q_req(q_req), .i_q_logical(q_logical),
    .o_q_valid(q_valid), .o_q_phys(q_phys), .o_q_ok(q_ok),
    .i_dump_req(dump_req), .o_dump_valid(dump_valid), .o_dump_idx(dump_idx),
    .o_dump_data(dump_data), .o_busy(busy), .o_build_done(build_done),
    .o_map_fail(map_fail), .o_lane_ok(lane_ok), .o_healthy_cnt(healthy_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [PHYS-1:0]  m_mask;
  int               m_tbl [LANES];
  logic [LANES-1:0] m_ok;
  int               m_healthy;
  bit               m_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    m_mask = '0;
    for (int i = 0; i < LANES; i++) m_tbl[i] = i;
    m_ok = '1;
    m_healthy = PHYS;
    m_fail = 0;
  endtask

  // Healthy lanes in ascending order fill logical slots; leftovers keep their old lane.
  task automatic ref_build();
    int healthy[$];
    for (int p = 0; p < PHYS; p++) if (!m_mask[p]) healthy.push_back(p);
    for (int i = 0; i < LANES; i++) begin
      if (i < healthy.size()) begin
        m_tbl[i] = healthy[i];
        m_ok[i] = 1'b1;
      end else begin
        m_ok[i] = 1'b0;
      end
    end
    m_healthy = healthy.size();
    m_fail = (healthy.size() < LANES);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (build_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("build_done_seen", 32'(build_done), 32'd1);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_lane_ok"}, 32'(lane_ok), 32'(m_ok));
    chk({tag, "_healthy"}, 32'(healthy_cnt), 32'(m_healthy));
    chk({tag, "_map_fail"}, 32'(map_fail), 32'(m_fail));
  endtask

  task automatic commit(input string tag);
    int n;
    wait_done(n);
    tick();
    ref_build();
    check_status(tag);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_dump(input string tag);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      chk({tag, "_dvalid"}, 32'(dump_valid), 32'd1);
      chk({tag, "_didx"}, 32'(dump_idx), 32'(i));
      chk({tag, "_ddata"}, 32'(dump_data), 32'(m_tbl[i]));
      tick();
    end
    chk({tag, "_dend"}, 32'(dump_valid), 32'd0);
  endtask

  task automatic query(input string tag, input int idx, input bit byp);
    int ep;
    bit eo;
    q_req = 1'b1;
    q_logical = AW'(idx);
    bypass = byp;
    tick();
    q_req = 1'b0;
    bypass = 1'b0;
    if (idx >= LANES) begin ep = 0; eo = 0; end
    else if (byp) begin ep = idx; eo = 1; end
    else begin ep = m_tbl[idx]; eo = m_ok[idx]; end
    chk({tag, "_qvalid"}, 32'(q_valid), 32'd1);
    chk({tag, "_qphys"}, 32'(q_phys), 32'(ep));
    chk({tag, "_qok"}, 32'(q_ok), 32'(eo));
  endtask

  task automatic report_fault(input int lane);
    fault_valid = 1'b1;
    fault_lane = AW'(lane);
    tick();
    fault_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pulses, old_phys, new_phys, action, lane;
    bit committed, pd;

    // Reset values
    reset_model();
    repeat (3) tick();
    chk("rst_lane_ok", 32'(lane_ok), 32'hFF);
    chk("rst_healthy", 32'(healthy_cnt), 32'(PHYS));
    chk("rst_map_fail", 32'(map_fail), 32'd0);
    chk("rst_qvalid", 32'(q_valid), 32'd0);
    chk("rst_dvalid", 32'(dump_valid), 32'd0);
    chk("rst_done", 32'(build_done), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    query("rst_q5", 5, 0);

    // Mask load: request presented in cycle T, accepted at the next edge,
    // build_done in cycle T+PHYS+1, i.e. PHYS edges after the accepting edge.
    load_valid = 1'b1;
    load_mask = 10'b0000000100;
    tick();
    load_valid = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("build_latency", 32'(n), 32'(PHYS));
    tick();
    m_mask = 10'b0000000100;
    ref_build();
    check_status("load");
    check_dump("load");

    report_fault(5);
    m_mask[5] = 1'b1;
    commit("f5");
    check_dump("f5");

    // Fault lane 0 while querying logical 3 every cycle: the old entry is returned
    // until the query presented after the build_done cycle.
    old_phys = m_tbl[3];
    m_mask[0] = 1'b1;
    ref_build();
    new_phys = m_tbl[3];
    fault_valid = 1'b1;
    fault_lane = AW'(0);
    q_req = 1'b1;
    q_logical = AW'(3);
    committed = 0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      pd = build_done;
      tick();
      fault_valid = 1'b0;
      chk("q3_rebuild", 32'(q_phys), committed ? 32'(new_phys) : 32'(old_phys));
      if (pd) begin
        committed = 1;
        pulses++;
      end
    end
    q_req = 1'b0;
    chk("q3_pulses", 32'(pulses), 32'd1);
    check_status("f0");
    query("f0_q7", 7, 0);
    check_dump("f0");

    query("byp_q6", 6, 1);
    query("q9", 9, 0);
    query("byp_q9", 9, 1);

    // Out-of-range fault lane is dropped
    report_fault(12);
    chk("f12_busy", 32'(busy), 32'd0);
    pulses = 0;
    repeat (15) begin
      if (build_done) pulses++;
      tick();
    end
    chk("f12_pulses", 32'(pulses), 32'd0);
    check_status("f12");

    // Fault during BUILD queues a second build
    report_fault(7);
    repeat (3) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_ready", 32'(load_ready), 32'd0);
    report_fault(9);
    pulses = 0;
    repeat (60) begin
      if (build_done) pulses++;
      tick();
    end
    chk("two_pulses", 32'(pulses), 32'd2);
    m_mask[7] = 1'b1;
    ref_build();
    m_mask[9] = 1'b1;
    ref_build();
    check_status("twice");
    check_dump("twice");

    // Reset in the middle of a build
    load_valid = 1'b1;
    load_mask = 10'b1111100000;
    tick();
    load_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    reset_model();
    chk("midrst_busy", 32'(busy), 32'd0);
    check_status("midrst");
    chk("midrst_qvalid", 32'(q_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_dump("midrst");

    // Randomized operations from IDLE
    for (int it = 0; it < 40; it++) begin
      action = $urandom_range(0, 2);
      if (action == 0) begin
        load_mask = PHYS'($urandom & $urandom);
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        m_mask = load_mask;
        commit("rnd_load");
        check_dump("rnd_load");
      end else if (action == 1) begin
        lane = $urandom_range(0, 11);
        report_fault(lane);
        if (lane < PHYS) begin
          m_mask[lane] = 1'b1;
          commit("rnd_fault");
        end else begin
          chk("rnd_badlane_busy", 32'(busy), 32'd0);
        end
      end else begin
        for (int k = 0; k < 3; k++)
          query("rnd_q", $urandom_range(0, 9), 1'($urandom_range(0, 1)));
      end
    end
    check_status("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_remap_table.md
Name: lane_remap_table

Overview:
- Parametrised successor to the row mapping table.
- Maps LANES logical PE rows/columns onto LANES+SPARES physical lanes, skipping faulty physical lanes.
- A sequential scan FSM rebuilds the mapping from a fault mask. Builds go into a shadow table that is committed atomically, so queries never see a partial map.
- Also accepts runtime fault reports, offers a bypass (identity) mode, and streams the committed table out for eNVM persistence.

Parameters:
- LANES, 8, number of logical lanes presented to the systolic array.
- SPARES, 2, number of spare physical lanes; PHYS = LANES+SPARES.
- ADDR_WIDTH, $clog2(LANES+SPARES), width of a physical lane index.
- CNT_WIDTH, $clog2(LANES+SPARES+1), width of the healthy-lane count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  fault-mask load request.
- load_mask  in  PHYS  1 = physical lane faulty.
- load_ready  out  1  high only in IDLE.
- fault_valid  in  1  runtime fault report, single-cycle pulse.
- fault_lane  in  ADDR_WIDTH  physical index of the reported fault.
- bypass  in  1  1 = identity mapping on queries.
- q_req  in  1  query strobe.
- q_logical  in  ADDR_WIDTH  logical lane to translate.
- q_valid  out  1  query response valid.
- q_phys  out  ADDR_WIDTH  mapped physical lane.
- q_ok  out  1  mapped lane is healthy and valid.
- dump_req  in  1  start table dump.
- dump_valid  out  1  dump beat valid.
- dump_idx  out  ADDR_WIDTH  logical index of the beat.
- dump_data  out  ADDR_WIDTH  committed physical lane for that index.
- busy  out  1  state != IDLE.
- build_done  out  1  one-cycle pulse when a build commits.
- map_fail  out  1  last build found fewer than LANES healthy lanes.
- lane_ok  out  LANES  per-logical-lane valid bits from the committed map.
- healthy_cnt  out  CNT_WIDTH  healthy physical lanes counted by the last build.

Behaviour:
- Reset values:
  - fault_mask = 0; committed and shadow table[i] = i.
  - lane_ok = all 1; healthy_cnt = PHYS; map_fail = 0.
  - q_valid = q_ok = q_phys = 0; dump_valid = dump_idx = dump_data = 0.
  - build_done = 0; pending = 0; state = IDLE.
  - Reset mid-build or mid-dump aborts immediately to these values.
- States: IDLE, BUILD, FINISH, DUMP.
- IDLE, in priority order:
  - load_valid: fault_mask <= load_mask | (fault_valid ? onehot(fault_lane) : 0); go to BUILD.
  - else fault_valid: fault_mask bit fault_lane <= 1; go to BUILD.
  - else pending: clear pending; go to BUILD.
  - else dump_req: go to DUMP.
- fault_lane >= PHYS is ignored and causes no build.
- BUILD:
  - Counter p runs 0..PHYS-1, one per cycle; write pointer l starts at 0.
  - Each cycle, if !fault_mask[p] and l < LANES: shadow[l] <= p, shadow_ok[l] <= 1, l <= l+1.
  - After p = PHYS-1, go to FINISH.
  - Exactly PHYS cycles.
- FINISH (1 cycle):
  - Commit shadow to the committed table and lane_ok. Entries l..LANES-1 get lane_ok = 0 and keep their prior physical value.
  - healthy_cnt <= count of zeros in fault_mask; map_fail <= (l < LANES); build_done = 1.
  - Return to IDLE.
  - Latency: request accepted at cycle T, build_done at T+PHYS+1.
- fault_valid during BUILD, FINISH or DUMP: OR the bit into a pending mask and set pending. On re-entering IDLE, merge pending into fault_mask and start a new build. Reports are never lost.
- load_valid while not IDLE: not accepted (load_ready = 0); the requester holds it.
- DUMP:
  - LANES beats on consecutive cycles with dump_valid = 1, dump_idx = 0..LANES-1, dump_data = committed table.
  - Then return to IDLE.
  - dump_req outside IDLE is ignored.
- Query:
  - 1-cycle registered latency; served in every state, always from the committed table.
  - q_valid <= q_req.
  - Normal: q_phys <= table[q_logical], q_ok <= lane_ok[q_logical].
  - bypass = 1: q_phys <= q_logical, q_ok <= 1.
  - q_logical >= LANES: q_phys = 0, q_ok = 0, in either mode.

Test Plan (LANES=8, SPARES=2):
- Reset; query 5 -> next cycle q_valid = 1, q_phys = 5, q_ok = 1, map_fail = 0, healthy_cnt = 10.
- load_mask = 10'b0000000100 -> build_done 11 cycles after acceptance; dump gives 0,1,3,4,5,6,7,8; healthy_cnt = 9; map_fail = 0.
- Then fault_valid, lane 5 -> map 0,1,3,4,6,7,8,9; healthy_cnt = 8; lane_ok = 8'hFF.
- Then fault lane 0 -> healthy_cnt = 7, map_fail = 1, lane_ok[7] = 0; query 7 -> q_ok = 0.
- Query 3 on every cycle of a rebuild -> old value returned until the cycle after build_done, then the new value; never a mixed map.
- fault_valid during BUILD -> second build starts automatically, two build_done pulses. bypass = 1 with query 6 -> q_phys = 6, q_ok = 1. Query 9 -> q_ok = 0. fault_lane = 12 -> no build.
